// File: rtl/ps2_keyboard_mmio_pkg.sv
// Shared constants for the PS/2 keyboard front end: Hack key codes, PS/2 prefixes,
// receiver state encoding and a case-folding helper for key identity.
package ps2_keyboard_mmio_pkg;

    localparam logic [7:0] PS2_EXT    = 8'hE0;
    localparam logic [7:0] PS2_BRK    = 8'hF0;
    localparam logic [7:0] PS2_LSHIFT = 8'h12;
    localparam logic [7:0] PS2_RSHIFT = 8'h59;

    localparam logic [15:0] KEY_NEWLINE   = 16'd128;
    localparam logic [15:0] KEY_BACKSPACE = 16'd129;
    localparam logic [15:0] KEY_LEFT      = 16'd130;
    localparam logic [15:0] KEY_UP        = 16'd131;
    localparam logic [15:0] KEY_RIGHT     = 16'd132;
    localparam logic [15:0] KEY_DOWN      = 16'd133;
    localparam logic [15:0] KEY_HOME      = 16'd134;
    localparam logic [15:0] KEY_END       = 16'd135;
    localparam logic [15:0] KEY_PGUP      = 16'd136;
    localparam logic [15:0] KEY_PGDN      = 16'd137;
    localparam logic [15:0] KEY_INSERT    = 16'd138;
    localparam logic [15:0] KEY_DELETE    = 16'd139;
    localparam logic [15:0] KEY_ESC       = 16'd140;
    localparam logic [15:0] KEY_F1        = 16'd141;

    typedef enum logic [1:0] {StIdle, StData, StParity, StStop} rx_state_e;

    // Upper-case letters map onto their lower-case code so a break matches either case.
    function automatic logic [15:0] fold_case(input logic [15:0] code);
        if (code >= 16'd65 && code <= 16'd90) begin
            return code + 16'd32;
        end
        return code;
    endfunction

endpackage

// File: rtl/ps2_keyboard_mmio_scan.sv
// Combinational scan-code-set-2 to Hack key code lookup; mapped=0 for unknown codes.
module ps2_scan_to_hack
    import ps2_keyboard_mmio_pkg::*;
(
    input  logic [7:0]  scan,
    input  logic        ext,
    input  logic        shift,
    output logic [15:0] code,
    output logic        mapped
);

    logic [4:0] letter;  // 31 = not a letter
    logic [3:0] digit;   // 15 = not a digit

    always_comb begin
        code   = '0;
        letter = 5'd31;
        digit  = 4'd15;
        if (ext) begin
            case (scan)
                8'h6B: code = KEY_LEFT;    8'h75: code = KEY_UP;
                8'h74: code = KEY_RIGHT;   8'h72: code = KEY_DOWN;
                8'h6C: code = KEY_HOME;    8'h69: code = KEY_END;
                8'h7D: code = KEY_PGUP;    8'h7A: code = KEY_PGDN;
                8'h70: code = KEY_INSERT;  8'h71: code = KEY_DELETE;
                default: code = '0;
            endcase
        end else begin
            case (scan)
                8'h1C: letter = 5'd0;   8'h32: letter = 5'd1;   8'h21: letter = 5'd2;
                8'h23: letter = 5'd3;   8'h24: letter = 5'd4;   8'h2B: letter = 5'd5;
                8'h34: letter = 5'd6;   8'h33: letter = 5'd7;   8'h43: letter = 5'd8;
                8'h3B: letter = 5'd9;   8'h42: letter = 5'd10;  8'h4B: letter = 5'd11;
                8'h3A: letter = 5'd12;  8'h31: letter = 5'd13;  8'h44: letter = 5'd14;
                8'h4D: letter = 5'd15;  8'h15: letter = 5'd16;  8'h2D: letter = 5'd17;
                8'h1B: letter = 5'd18;  8'h2C: letter = 5'd19;  8'h3C: letter = 5'd20;
                8'h2A: letter = 5'd21;  8'h1D: letter = 5'd22;  8'h22: letter = 5'd23;
                8'h35: letter = 5'd24;  8'h1A: letter = 5'd25;
                8'h45: digit = 4'd0;    8'h16: digit = 4'd1;    8'h1E: digit = 4'd2;
                8'h26: digit = 4'd3;    8'h25: digit = 4'd4;    8'h2E: digit = 4'd5;
                8'h36: digit = 4'd6;    8'h3D: digit = 4'd7;    8'h3E: digit = 4'd8;
                8'h46: digit = 4'd9;
                8'h29: code = 16'd32;
                8'h5A: code = KEY_NEWLINE;
                8'h66: code = KEY_BACKSPACE;
                8'h76: code = KEY_ESC;
                8'h05: code = KEY_F1;           8'h06: code = KEY_F1 + 16'd1;
                8'h04: code = KEY_F1 + 16'd2;   8'h0C: code = KEY_F1 + 16'd3;
                8'h03: code = KEY_F1 + 16'd4;   8'h0B: code = KEY_F1 + 16'd5;
                8'h83: code = KEY_F1 + 16'd6;   8'h0A: code = KEY_F1 + 16'd7;
                8'h01: code = KEY_F1 + 16'd8;   8'h09: code = KEY_F1 + 16'd9;
                8'h78: code = KEY_F1 + 16'd10;  8'h07: code = KEY_F1 + 16'd11;
                default: code = '0;
            endcase
            if (letter != 5'd31) begin
                code = (shift ? 16'd65 : 16'd97) + {11'd0, letter};
            end
            if (digit != 4'd15) begin
                code = 16'd48 + {12'd0, digit};
            end
        end
        mapped = (code != '0);
    end

endmodule

// File: rtl/ps2_keyboard_mmio.sv
// PS/2 keyboard receiver and decoder; publishes the held Hack key code to the keyboard
// MMIO word through a level req/ack write handshake.
module ps2_keyboard_mmio
    import ps2_keyboard_mmio_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 50000,
    parameter logic [14:0] KBD_ADDR       = 15'd24576
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [15:0] kbd_data,
    output logic [14:0] kbd_address,
    output logic        kbd_req,
    input  logic        kbd_ack,
    output logic        frame_err
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT_CYCLES - 1);

    logic [1:0]    ps2c_sync_q, ps2d_sync_q;
    logic          ps2c_prev_q;
    logic          fall, ps2d;
    rx_state_e     state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          parity_ok_q, parity_ok_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          byte_valid_q, byte_valid_d;
    logic          frame_err_q, frame_err_d;
    logic          ext_q, ext_d, brk_q, brk_d;
    logic          shift_l_q, shift_l_d, shift_r_q, shift_r_d;
    logic [15:0]   held_q, held_d, last_q, last_d, data_q, data_d;
    logic          req_q, req_d;
    logic [15:0]   lut_code;
    logic          lut_mapped;

    assign fall = ps2c_prev_q & ~ps2c_sync_q[1];
    assign ps2d = ps2d_sync_q[1];

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shreg_d      = shreg_q;
        parity_ok_d  = parity_ok_q;
        timer_d      = timer_q;
        byte_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        if (state_q != StIdle) begin
            timer_d = timer_q + TW'(1);
        end
        if (fall) begin
            timer_d = '0;
            case (state_q)
                StIdle: begin
                    if (!ps2d) begin
                        state_d   = StData;
                        bit_cnt_d = 3'd0;
                    end
                end
                StData: begin
                    shreg_d   = {ps2d, shreg_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = StParity;
                end
                StParity: begin
                    parity_ok_d = ^{shreg_q, ps2d};
                    state_d     = StStop;
                end
                StStop: begin
                    if (ps2d && parity_ok_q) byte_valid_d = 1'b1;
                    else                     frame_err_d  = 1'b1;
                    state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end else if (state_q != StIdle && timer_q == TIMER_MAX) begin
            frame_err_d = 1'b1;
            state_d     = StIdle;
            timer_d     = '0;
        end
    end

    ps2_scan_to_hack u_scan (
        .scan   (shreg_q),
        .ext    (ext_q),
        .shift  (shift_l_q | shift_r_q),
        .code   (lut_code),
        .mapped (lut_mapped)
    );

    always_comb begin
        ext_d     = ext_q;
        brk_d     = brk_q;
        shift_l_d = shift_l_q;
        shift_r_d = shift_r_q;
        held_d    = held_q;
        if (byte_valid_q) begin
            if (shreg_q == PS2_EXT) begin
                ext_d = 1'b1;
            end else if (shreg_q == PS2_BRK) begin
                brk_d = 1'b1;
            end else begin
                ext_d = 1'b0;
                brk_d = 1'b0;
                if (shreg_q == PS2_LSHIFT) begin
                    shift_l_d = ~brk_q;
                end else if (shreg_q == PS2_RSHIFT) begin
                    shift_r_d = ~brk_q;
                end else if (lut_mapped) begin
                    if (!brk_q) held_d = lut_code;
                    else if (fold_case(lut_code) == fold_case(held_q)) held_d = '0;
                end
            end
        end
    end

    // Data follows the held code while a request is pending so the newest key wins.
    always_comb begin
        req_d  = req_q;
        data_d = data_q;
        last_d = last_q;
        if (req_q) begin
            if (kbd_ack) begin
                req_d  = 1'b0;
                last_d = data_q;
            end else begin
                data_d = held_q;
            end
        end else if (held_q != last_q) begin
            req_d  = 1'b1;
            data_d = held_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ps2c_sync_q  <= 2'b11;
            ps2d_sync_q  <= 2'b11;
            ps2c_prev_q  <= 1'b1;
            state_q      <= StIdle;
            bit_cnt_q    <= '0;
            shreg_q      <= '0;
            parity_ok_q  <= 1'b0;
            timer_q      <= '0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            ext_q        <= 1'b0;
            brk_q        <= 1'b0;
            shift_l_q    <= 1'b0;
            shift_r_q    <= 1'b0;
            held_q       <= '0;
            last_q       <= '0;
            data_q       <= '0;
            req_q        <= 1'b0;
        end else begin
            ps2c_sync_q  <= {ps2c_sync_q[0], ps2_clk};
            ps2d_sync_q  <= {ps2d_sync_q[0], ps2_data};
            ps2c_prev_q  <= ps2c_sync_q[1];
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shreg_q      <= shreg_d;
            parity_ok_q  <= parity_ok_d;
            timer_q      <= timer_d;
            byte_valid_q <= byte_valid_d;
            frame_err_q  <= frame_err_d;
            ext_q        <= ext_d;
            brk_q        <= brk_d;
            shift_l_q    <= shift_l_d;
            shift_r_q    <= shift_r_d;
            held_q       <= held_d;
            last_q       <= last_d;
            data_q       <= data_d;
            req_q        <= req_d;
        end
    end

    assign kbd_data    = data_q;
    assign kbd_address = KBD_ADDR;
    assign kbd_req     = req_q;
    assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_ps2_keyboard_mmio.sv
// Self-checking bench: randomized PS/2 frames against a key-press model of the keyboard word.
module tb_ps2_keyboard_mmio;

    localparam int unsigned TMO = 400;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic        kbd_ack;
    logic [15:0] kbd_data;
    logic [14:0] kbd_address;
    logic        kbd_req;
    logic        frame_err;

    int total = 0;
    int bad = 0;
    int err_cnt = 0;
    int rise_at = -1;
    bit ack_auto = 1'b0;
    bit ack_force = 1'b0;
    logic [15:0] obs[$];
    logic [15:0] exp_q[$];

    int lut_n[256];
    int lut_e[256];
    bit m_ext, m_brk, m_shl, m_shr;
    int m_held, m_key;

    always #5 clk = ~clk;

    ps2_keyboard_mmio #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk         (clk),
        .reset       (reset),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .kbd_data    (kbd_data),
        .kbd_address (kbd_address),
        .kbd_req     (kbd_req),
        .kbd_ack     (kbd_ack),
        .frame_err   (frame_err)
    );

    // Memory side: acknowledges on request and logs every accepted write.
    initial begin
        kbd_ack = 1'b0;
        forever begin
            @(negedge clk);
            kbd_ack = kbd_req && (ack_force || (ack_auto && $urandom_range(0, 3) == 0));
            if (kbd_ack) obs.push_back(kbd_data);
            if (frame_err) err_cnt++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, required the bench to finish");
        $fatal(1, "watchdog expired");
    end

    function automatic string qstr(input logic [15:0] q[$]);
        string s = "";
        foreach (q[i]) s = {s, $sformatf("%0d ", q[i])};
        return s;
    endfunction

    task automatic init_lut();
        logic [7:0] ls[26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                               8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                               8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
        logic [7:0] ds[10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E,
                               8'h46};
        logic [7:0] fk[12] = '{8'h05, 8'h06, 8'h04, 8'h0C, 8'h03, 8'h0B, 8'h83, 8'h0A, 8'h01,
                               8'h09, 8'h78, 8'h07};
        logic [7:0] es[10] = '{8'h6B, 8'h75, 8'h74, 8'h72, 8'h6C, 8'h69, 8'h7D, 8'h7A, 8'h70,
                               8'h71};
        foreach (lut_n[i]) begin
            lut_n[i] = 0;
            lut_e[i] = 0;
        end
        for (int i = 0; i < 26; i++) lut_n[ls[i]] = 97 + i;
        for (int i = 0; i < 10; i++) lut_n[ds[i]] = 48 + i;
        for (int i = 0; i < 12; i++) lut_n[fk[i]] = 141 + i;
        for (int i = 0; i < 10; i++) lut_e[es[i]] = 130 + i;
        lut_n[8'h29] = 32;
        lut_n[8'h5A] = 128;
        lut_n[8'h66] = 129;
        lut_n[8'h76] = 140;
    endtask

    task automatic model_reset();
        m_ext = 0; m_brk = 0; m_shl = 0; m_shr = 0; m_held = 0; m_key = -1;
    endtask

    function automatic void model_set(input int code);
        if (code != m_held) exp_q.push_back(16'(code));
        m_held = code;
    endfunction

    // Key-press model: remembers which physical key produced the held code.
    function automatic void model_byte(input logic [7:0] b);
        int base, code, key;
        if (b == 8'hE0) m_ext = 1;
        else if (b == 8'hF0) m_brk = 1;
        else begin
            base = m_ext ? lut_e[b] : lut_n[b];
            key  = (int'(m_ext) << 8) | int'(b);
            if (b == 8'h12) m_shl = !m_brk;
            else if (b == 8'h59) m_shr = !m_brk;
            else if (base != 0) begin
                code = base;
                if ((m_shl || m_shr) && base >= 97 && base <= 122) code = base - 32;
                if (!m_brk) begin
                    model_set(code);
                    m_key = key;
                end else if (m_held != 0 && key == m_key) begin
                    model_set(0);
                end
            end
            m_ext = 0;
            m_brk = 0;
        end
    endfunction

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Sends n frame bits LSB first; records cycles from the stop-bit fall to a kbd_req rise.
    task automatic send_bits(input logic [10:0] bits, input int n);
        int half;
        logic req_before;
        for (int i = 0; i < n; i++) begin
            half = $urandom_range(6, 10);
            ps2_data = bits[i];
            wait_cyc(half);
            req_before = kbd_req;
            ps2_clk = 1'b0;
            for (int k = 1; k <= half; k++) begin
                @(posedge clk);
                #1;
                if (i == 10 && rise_at < 0 && !req_before && kbd_req) rise_at = k;
            end
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_bits({1'b1, ~^b, b, 1'b0}, 11);
        model_byte(b);
        wait_cyc($urandom_range(2, 10));
    endtask

    task automatic settle();
        int n = 0;
        wait_cyc(10);
        while (kbd_req && n < 1000) begin
            wait_cyc(1);
            n++;
        end
        total++;
        if (kbd_req) begin
            bad++;
            $display("FAIL settle: kbd_req=%0d after 1000 cycles, required 0", kbd_req);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        wait_cyc(3);
        total += 4;
        if (kbd_data !== 16'd0) begin bad++; $display("FAIL rst_data: got %0d want 0", kbd_data); end
        if (kbd_req !== 1'b0) begin bad++; $display("FAIL rst_req: got %b want 0", kbd_req); end
        if (frame_err !== 1'b0) begin bad++; $display("FAIL rst_err: got %b want 0", frame_err); end
        if (kbd_address !== 15'd24576) begin
            bad++; $display("FAIL rst_addr: got %0d want 24576", kbd_address);
        end
        reset = 1'b0;
        model_reset();
        wait_cyc(2);
    endtask

    task automatic test_make_break();
        logic [15:0] want[$];
        bit ok;
        obs.delete();
        ack_auto = 0;
        rise_at = -1;
        send_byte(8'h1C);
        total += 3;
        if (rise_at !== 5) begin bad++; $display("FAIL req_latency: got %0d want 5", rise_at); end
        if (kbd_req !== 1'b1) begin bad++; $display("FAIL mk_req: got %b want 1", kbd_req); end
        if (kbd_data !== 16'd97) begin bad++; $display("FAIL mk_data: got %0d want 97", kbd_data); end
        wait_cyc(20);
        total++;
        if (kbd_req !== 1'b1) begin bad++; $display("FAIL req_hold: got %b want 1", kbd_req); end
        ack_force = 1;
        wait_cyc(2);
        ack_force = 0;
        total++;
        if (kbd_req !== 1'b0) begin bad++; $display("FAIL ack_drop: got %b want 0", kbd_req); end
        ack_auto = 1;
        send_byte(8'hF0);
        send_byte(8'h1C);
        settle();
        want = '{16'd97, 16'd0};
        ok = (obs.size() == want.size());
        foreach (want[i]) if (ok && obs[i] !== want[i]) ok = 0;
        total++;
        if (!ok) begin
            bad++; $display("FAIL make_break_writes: got [%s] want [%s]", qstr(obs), qstr(want));
        end
    endtask

    task automatic test_shift();
        logic [15:0] want[$];
        bit ok;
        obs.delete();
        send_byte(8'h12);
        settle();
        total++;
        if (obs.size() != 0) begin
            bad++; $display("FAIL shift_alone: got %0d writes want 0", obs.size());
        end
        send_byte(8'h1C);
        send_byte(8'hF0); send_byte(8'h1C);
        send_byte(8'hF0); send_byte(8'h12);
        settle();
        want = '{16'd65, 16'd0};
        ok = (obs.size() == want.size());
        foreach (want[i]) if (ok && obs[i] !== want[i]) ok = 0;
        total++;
        if (!ok) begin
            bad++; $display("FAIL shift_writes: got [%s] want [%s]", qstr(obs), qstr(want));
        end
    endtask

    task automatic test_ext_repeat();
        logic [15:0] want[$];
        bit ok;
        obs.delete();
        send_byte(8'hE0); send_byte(8'h75);
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
        settle();
        want = '{16'd131, 16'd0};
        ok = (obs.size() == want.size());
        foreach (want[i]) if (ok && obs[i] !== want[i]) ok = 0;
        total++;
        if (!ok) begin
            bad++; $display("FAIL ext_writes: got [%s] want [%s]", qstr(obs), qstr(want));
        end
        obs.delete();
        repeat (3) send_byte(8'h5A);
        settle();
        want = '{16'd128};
        ok = (obs.size() == want.size());
        foreach (want[i]) if (ok && obs[i] !== want[i]) ok = 0;
        total++;
        if (!ok) begin
            bad++; $display("FAIL repeat_writes: got [%s] want [%s]", qstr(obs), qstr(want));
        end
        send_byte(8'hF0); send_byte(8'h5A);
        settle();
    endtask

    task automatic test_parity_err();
        logic [15:0] want[$];
        bit ok;
        logic [7:0] b = 8'h1C;
        obs.delete();
        err_cnt = 0;
        send_bits({1'b1, ^b, b, 1'b0}, 11);
        wait_cyc(10);
        total += 3;
        if (err_cnt != 1) begin bad++; $display("FAIL parity_err: got %0d pulses want 1", err_cnt); end
        if (obs.size() != 0) begin bad++; $display("FAIL parity_write: got %0d want 0", obs.size()); end
        if (kbd_req !== 1'b0) begin bad++; $display("FAIL parity_req: got %b want 0", kbd_req); end
        send_byte(8'h29);
        settle();
        want = '{16'd32};
        ok = (obs.size() == want.size());
        foreach (want[i]) if (ok && obs[i] !== want[i]) ok = 0;
        total++;
        if (!ok) begin
            bad++; $display("FAIL after_parity: got [%s] want [%s]", qstr(obs), qstr(want));
        end
        send_byte(8'hF0); send_byte(8'h29);
        settle();
    endtask

    task automatic test_timeout();
        logic [15:0] want[$];
        bit ok;
        logic [7:0] b = 8'h1C;
        obs.delete();
        err_cnt = 0;
        send_bits({1'b1, ~^b, b, 1'b0}, 5);
        wait_cyc(TMO + 2);
        total++;
        if (err_cnt != 1) begin bad++; $display("FAIL timeout_err: got %0d pulses want 1", err_cnt); end
        send_byte(8'h1C);
        settle();
        want = '{16'd97};
        ok = (obs.size() == want.size());
        foreach (want[i]) if (ok && obs[i] !== want[i]) ok = 0;
        total++;
        if (!ok) begin
            bad++; $display("FAIL after_timeout: got [%s] want [%s]", qstr(obs), qstr(want));
        end
        send_byte(8'hF0); send_byte(8'h1C);
        settle();
    endtask

    task automatic test_tracking();
        obs.delete();
        ack_auto = 0;
        send_byte(8'h1C);
        total++;
        if (kbd_req !== 1'b1 || kbd_data !== 16'd97) begin
            bad++; $display("FAIL track_first: got req=%b data=%0d want req=1 data=97", kbd_req, kbd_data);
        end
        send_byte(8'h29);
        total += 2;
        if (kbd_req !== 1'b1 || kbd_data !== 16'd32) begin
            bad++; $display("FAIL track_second: got req=%b data=%0d want req=1 data=32", kbd_req, kbd_data);
        end
        if (obs.size() != 0) begin bad++; $display("FAIL track_noack: got %0d want 0", obs.size()); end
        ack_force = 1;
        wait_cyc(2);
        ack_force = 0;
        wait_cyc(3);
        total += 2;
        if (obs.size() != 1 || obs[0] !== 16'd32) begin
            bad++; $display("FAIL track_write: got [%s] want [32]", qstr(obs));
        end
        if (kbd_req !== 1'b0) begin bad++; $display("FAIL track_req: got %b want 0", kbd_req); end
        ack_auto = 1;
        send_byte(8'hF0); send_byte(8'h29);
        settle();
    endtask

    task automatic test_reset_mid();
        logic [7:0] b = 8'h1C;
        obs.delete();
        send_bits({1'b1, ~^b, b, 1'b0}, 4);
        reset = 1'b1;
        wait_cyc(2);
        total += 3;
        if (kbd_req !== 1'b0 || kbd_data !== 16'd0) begin
            bad++; $display("FAIL mid_rst_out: got req=%b data=%0d want 0 0", kbd_req, kbd_data);
        end
        if (frame_err !== 1'b0) begin bad++; $display("FAIL mid_rst_err: got %b want 0", frame_err); end
        if (kbd_address !== 15'd24576) begin
            bad++; $display("FAIL mid_rst_addr: got %0d want 24576", kbd_address);
        end
        reset = 1'b0;
        model_reset();
        wait_cyc(50);
        total++;
        if (kbd_req !== 1'b0 || obs.size() != 0) begin
            bad++; $display("FAIL mid_rst_nowrite: got req=%b writes=%0d want 0 0", kbd_req, obs.size());
        end
        send_byte(8'h1C);
        settle();
        total++;
        if (obs.size() != 1 || obs[0] !== 16'd97) begin
            bad++; $display("FAIL mid_rst_after: got [%s] want [97]", qstr(obs));
        end
        send_byte(8'hF0); send_byte(8'h1C);
        settle();
    endtask

    task automatic test_random();
        logic [8:0] pool[14] = '{9'h01C, 9'h032, 9'h016, 9'h029, 9'h05A, 9'h066, 9'h076,
                                 9'h005, 9'h012, 9'h059, 9'h175, 9'h16B, 9'h00E, 9'h11C};
        logic [8:0] k;
        logic [7:0] junk;
        int bad_frames = 0;
        bit ok;
        obs.delete();
        exp_q.delete();
        err_cnt = 0;
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                junk = 8'($urandom);
                send_bits({1'b1, ^junk, junk, 1'b0}, 11);
                wait_cyc(4);
                bad_frames++;
            end
            k = pool[$urandom_range(0, 13)];
            if (k[8]) send_byte(8'hE0);
            if ($urandom_range(0, 4) < 2) send_byte(8'hF0);
            send_byte(k[7:0]);
        end
        settle();
        ok = (obs.size() == exp_q.size());
        foreach (exp_q[i]) if (ok && obs[i] !== exp_q[i]) ok = 0;
        total += 2;
        if (!ok) begin
            bad++; $display("FAIL random_writes: got [%s] want [%s]", qstr(obs), qstr(exp_q));
        end
        if (err_cnt != bad_frames) begin
            bad++; $display("FAIL random_errs: got %0d want %0d", err_cnt, bad_frames);
        end
    endtask

    initial begin
        init_lut();
        model_reset();
        test_reset();
        test_make_break();
        test_shift();
        test_ext_repeat();
        test_parity_err();
        test_timeout();
        test_tracking();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
